// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared funct3 codes, FSM state type and access-size helper
//               for the dmem_ctrl data memory.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [2:0] size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_if
// Description : Request/response handshake bundle between the MEM stage
//               (master) and dmem_ctrl (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_if #(
    parameter int ADDR_W = 11
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/dmem_load_ext.sv
`default_nettype none
// ============================================================================
// Module      : dmem_load_ext
// Description : Byte-lane select and sign/zero extension of a 4-byte window.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_load_ext
    import dmem_pkg::*;
(
    input  wire logic [31:0] i_raw,
    input  wire logic [1:0]  i_lane,
    input  wire logic [2:0]  i_funct3,
    output logic      [31:0] o_rdata
);

    logic [31:0] w_sh;
    assign w_sh = i_raw >> {i_lane, 3'b000};

    always_comb begin
        o_rdata = 32'd0;
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_sh[7]}}, w_sh[7:0]};
            F3_H:    o_rdata = {{16{w_sh[15]}}, w_sh[15:0]};
            F3_W:    o_rdata = w_sh;
            F3_BU:   o_rdata = {24'd0, w_sh[7:0]};
            F3_HU:   o_rdata = {16'd0, w_sh[15:0]};
            default: o_rdata = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : Byte-addressable RV32 data memory with valid/ready handshake
//               and LATENCY wait states. Optional: DMEM_MISALIGN_SPLIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 512,
    parameter int ADDR_W      = 11,
    parameter int LATENCY     = 1,
    parameter int DATA_W      = 32
) (
    input wire logic clk,
    input wire logic rst_n,
    dmem_if.slave    bus
);

    localparam int               c_IDX_W    = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam logic [ADDR_W:0]  c_DEPTH    = (ADDR_W+1)'(DEPTH_BYTES);
    localparam logic [3:0]       c_CNT_INIT = 4'(LATENCY - 1);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("dmem_ctrl: DATA_W must be 32");
    end
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_ctrl: LATENCY must be in 1..15");
    end
    if (DEPTH_BYTES > 2**ADDR_W) begin : g_bad_depth
        $error("dmem_ctrl: DEPTH_BYTES exceeds address space");
    end

    function automatic logic is_bad(input logic we, input logic [2:0] f3,
                                    input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] last;
        logic            illegal;
        last    = {1'b0, a} + (ADDR_W+1)'(size_of(f3)) - (ADDR_W+1)'(1);
        illegal = we ? (f3 > F3_W) : (f3 == 3'b011 || f3[2:1] == 2'b11);
        return illegal || (last >= c_DEPTH);
    endfunction

    function automatic logic is_mis(input logic [2:0] f3, input logic [ADDR_W-1:0] a);
        return (size_of(f3) == 3'd2 && a[0]) || (size_of(f3) == 3'd4 && a[1:0] != 2'b00);
    endfunction

    state_t            r_state, w_next;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic [7:0]        r_mem [DEPTH_BYTES];

    logic              w_fire;
    logic              w_fault;
    logic              w_extra;
    logic [ADDR_W-1:0] w_base;
    logic [1:0]        w_lane;
    logic [31:0]       w_raw;
    logic [31:0]       w_ext;

    assign w_fire = (r_state == WAIT) && (r_cnt == 4'd0);

`ifdef DMEM_MISALIGN_SPLIT_EN
    // Misaligned in-range accesses go byte-wise from the start address and cost one more wait cycle.
    assign w_fault = is_bad(r_we, r_funct3, r_addr);
    assign w_extra = is_mis(bus.req_funct3, bus.req_addr)
                     && !is_bad(bus.req_we, bus.req_funct3, bus.req_addr);
    assign w_base  = r_addr;
    assign w_lane  = 2'b00;
`else
    assign w_fault = is_bad(r_we, r_funct3, r_addr) || is_mis(r_funct3, r_addr);
    assign w_extra = 1'b0;
    assign w_base  = {r_addr[ADDR_W-1:2], 2'b00};
    assign w_lane  = r_addr[1:0];
`endif

    for (genvar gi = 0; gi < 4; gi++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        assign w_ra             = w_base + ADDR_W'(gi);
        assign w_raw[8*gi +: 8] = r_mem[w_ra[c_IDX_W-1:0]];
    end

    dmem_load_ext u_load_ext (
        .i_raw    (w_raw),
        .i_lane   (w_lane),
        .i_funct3 (r_funct3),
        .o_rdata  (w_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bus.req_valid) begin
                r_cnt <= c_CNT_INIT + 4'(w_extra);
            end else if (r_state == WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.req_valid) w_next = WAIT;
            WAIT:    if (r_cnt == 4'd0) w_next = RESP;
            RESP:    if (bus.rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (r_state == IDLE);
        bus.rsp_valid = (r_state == RESP);
        bus.busy      = (r_state != IDLE);
        bus.rsp_rdata = r_rdata;
        bus.rsp_err   = r_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            if (r_state == IDLE && bus.req_valid) begin
                r_we     <= bus.req_we;
                r_funct3 <= bus.req_funct3;
                r_addr   <= bus.req_addr;
                r_wdata  <= bus.req_wdata;
            end
            if (w_fire) begin
                r_rdata <= (w_fault || r_we) ? 32'd0 : w_ext;
                r_err   <= w_fault;
            end
        end
    end

    // Storage is deliberately unreset; a store lands only on the WAIT->RESP edge.
    always_ff @(posedge clk) begin
        if (w_fire && r_we && !w_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (i < int'(size_of(r_funct3))) begin
                    r_mem[c_IDX_W'(r_addr + ADDR_W'(i))] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_ctrl
// Description : Scoreboard bench for dmem_ctrl at LATENCY 1 and 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int c_DEPTH  = 512;
    localparam int c_ADDR_W = 11;
`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit c_SPLIT = 1'b1;
`else
    localparam bit c_SPLIT = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_if #(.ADDR_W(c_ADDR_W)) u_if0 ();
    dmem_if #(.ADDR_W(c_ADDR_W)) u_if1 ();

    dmem_ctrl #(.DEPTH_BYTES(c_DEPTH), .ADDR_W(c_ADDR_W), .LATENCY(1), .DATA_W(32)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(u_if0.slave));
    dmem_ctrl #(.DEPTH_BYTES(c_DEPTH), .ADDR_W(c_ADDR_W), .LATENCY(3), .DATA_W(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(u_if1.slave));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t       exp_q [2][$];
    logic [7:0] mdl [2][c_DEPTH];
    bit         seen [2];
    bit         prev_hs [2];
    int         hold_lo [2];
    int         lat [2] = '{1, 3};
    int         n_vec = 0;
    int         n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, want, $time);
        end
    endtask

    // Reference: byte-array memory, access rules applied with plain arithmetic.
    function automatic void model(input int d, input bit we, input logic [2:0] f3,
                                  input int a, input logic [31:0] wd, output exp_t e);
        int          sz;
        bit          illegal, oor, mis;
        logic [31:0] v;
        sz      = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        oor     = (a + sz) > c_DEPTH;
        mis     = (a % sz) != 0;
        e.due   = cyc + 1 + lat[d] + ((c_SPLIT && mis && !illegal && !oor) ? 1 : 0);
        e.err   = illegal || oor || (mis && !c_SPLIT);
        e.rdata = 32'd0;
        if (!e.err) begin
            if (we) begin
                for (int i = 0; i < sz; i++) mdl[d][a+i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < sz; i++) v = v | (32'(mdl[d][a+i]) << (8*i));
                if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
                e.rdata = v;
            end
        end
    endfunction

    task automatic drive(input int d, input bit v, input bit we, input logic [2:0] f3,
                         input logic [10:0] a, input logic [31:0] wd);
        if (d == 0) begin
            u_if0.req_valid = v; u_if0.req_we = we; u_if0.req_funct3 = f3;
            u_if0.req_addr = a;  u_if0.req_wdata = wd;
        end else begin
            u_if1.req_valid = v; u_if1.req_we = we; u_if1.req_funct3 = f3;
            u_if1.req_addr = a;  u_if1.req_wdata = wd;
        end
    endtask

    function automatic bit rdy(input int d);
        return (d == 0) ? u_if0.req_ready : u_if1.req_ready;
    endfunction

    task automatic issue(input int d, input bit we, input logic [2:0] f3, input int a,
                         input logic [31:0] wd, input bit track);
        exp_t e;
        int   guard = 0;
        @(negedge clk);
        drive(d, 1'b1, we, f3, 11'(a), wd);
        while (!rdy(d)) begin
            if (guard > 200) begin
                n_vec++; n_err++;
                $display("FAIL dut%0d accept_timeout: req_ready=0, expected 1", d);
                drive(d, 1'b0, 1'b0, 3'd0, 11'd0, 32'd0);
                return;
            end
            guard++;
            @(negedge clk);
        end
        if (track) begin
            model(d, we, f3, a, wd, e);
            exp_q[d].push_back(e);
        end
        @(posedge clk);
        #1;
        drive(d, 1'b0, 1'b0, 3'd0, 11'd0, 32'd0);
    endtask

    task automatic check_reset(input int d);
        logic        qr, rv, re, bz;
        logic [31:0] rd;
        if (d == 0) begin
            qr = u_if0.req_ready; rv = u_if0.rsp_valid; re = u_if0.rsp_err;
            bz = u_if0.busy;      rd = u_if0.rsp_rdata;
        end else begin
            qr = u_if1.req_ready; rv = u_if1.rsp_valid; re = u_if1.rsp_err;
            bz = u_if1.busy;      rd = u_if1.rsp_rdata;
        end
        chk($sformatf("dut%0d reset req_ready", d), 32'(qr), 32'd1);
        chk($sformatf("dut%0d reset rsp_valid", d), 32'(rv), 32'd0);
        chk($sformatf("dut%0d reset rsp_rdata", d), rd, 32'd0);
        chk($sformatf("dut%0d reset rsp_err", d), 32'(re), 32'd0);
        chk($sformatf("dut%0d reset busy", d), 32'(bz), 32'd0);
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0",
                     exp_q[0].size() + exp_q[1].size());
        end
        repeat (2) @(negedge clk);
    endtask

    // Consumer side: random back-pressure, with forced-low windows for stall tests.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            bit r;
            if (hold_lo[d] > 0) begin
                hold_lo[d]--;
                r = 1'b0;
            end else begin
                r = ($urandom_range(0, 9) < 6);
            end
            if (d == 0) u_if0.rsp_ready = r;
            else        u_if1.rsp_ready = r;
        end
    end

    task automatic mon(input int d, input logic rv, input logic rr, input logic [31:0] rd,
                       input logic re, input logic qr, input logic bz);
        if (!rst_n) return;
        if (prev_hs[d]) begin
            chk($sformatf("dut%0d post_rsp req_ready", d), 32'(qr), 32'd1);
            chk($sformatf("dut%0d post_rsp busy", d), 32'(bz), 32'd0);
            chk($sformatf("dut%0d post_rsp rsp_valid", d), 32'(rv), 32'd0);
            prev_hs[d] = 1'b0;
        end
        if (rv) begin
            if (exp_q[d].size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL dut%0d unexpected_rsp: rsp_valid=1, expected 0", d);
            end else begin
                if (!seen[d]) begin
                    chk($sformatf("dut%0d latency cycle", d), 32'(cyc), 32'(exp_q[d][0].due));
                    seen[d] = 1'b1;
                end
                chk($sformatf("dut%0d rsp_rdata", d), rd, exp_q[d][0].rdata);
                chk($sformatf("dut%0d rsp_err", d), 32'(re), 32'(exp_q[d][0].err));
                chk($sformatf("dut%0d req_ready in RESP", d), 32'(qr), 32'd0);
                chk($sformatf("dut%0d busy in RESP", d), 32'(bz), 32'd1);
                if (rr) begin
                    void'(exp_q[d].pop_front());
                    seen[d]    = 1'b0;
                    prev_hs[d] = 1'b1;
                end
            end
        end else if (exp_q[d].size() != 0 && cyc >= exp_q[d][0].due) begin
            n_vec++; n_err++;
            $display("FAIL dut%0d late_rsp: rsp_valid=0 at cycle %0d, expected 1 by cycle %0d",
                     d, cyc, exp_q[d][0].due);
            void'(exp_q[d].pop_front());
            seen[d] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        mon(0, u_if0.rsp_valid, u_if0.rsp_ready, u_if0.rsp_rdata, u_if0.rsp_err,
            u_if0.req_ready, u_if0.busy);
        mon(1, u_if1.rsp_valid, u_if1.rsp_ready, u_if1.rsp_rdata, u_if1.rsp_err,
            u_if1.req_ready, u_if1.busy);
    end

    initial begin
        drive(0, 1'b0, 1'b0, 3'd0, 11'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 3'd0, 11'd0, 32'd0);
        u_if0.rsp_ready = 1'b0;
        u_if1.rsp_ready = 1'b0;
        hold_lo = '{0, 0};
        seen    = '{0, 0};
        prev_hs = '{0, 0};
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset(0);
        check_reset(1);
        rst_n = 1'b1;

        // Give every byte a known value first.
        for (int a = 0; a < c_DEPTH; a += 4) begin
            issue(0, 1'b1, F3_W, a, $urandom, 1'b1);
            issue(1, 1'b1, F3_W, a, $urandom, 1'b1);
        end
        wait_idle();

        issue(0, 1'b1, F3_W,  'h008, 32'hDEADBEEF, 1'b1);
        issue(0, 1'b0, F3_W,  'h008, 32'd0, 1'b1);
        issue(0, 1'b0, F3_B,  'h00B, 32'd0, 1'b1);
        issue(0, 1'b0, F3_BU, 'h00B, 32'd0, 1'b1);
        issue(0, 1'b0, F3_H,  'h00A, 32'd0, 1'b1);
        issue(0, 1'b0, F3_HU, 'h008, 32'd0, 1'b1);
        issue(0, 1'b1, F3_H,  'h005, 32'h0000_5A5A, 1'b1);
        issue(0, 1'b0, F3_W,  'h004, 32'd0, 1'b1);
        issue(0, 1'b0, F3_W,  'h1FE, 32'd0, 1'b1);
        issue(0, 1'b0, 3'b011, 'h010, 32'd0, 1'b1);
        issue(0, 1'b1, F3_W,  'h021, 32'hA1B2C3D4, 1'b1);
        issue(0, 1'b0, F3_W,  'h021, 32'd0, 1'b1);

        issue(1, 1'b1, F3_W, 'h008, 32'hCAFEF00D, 1'b1);
        hold_lo[1] = 8;
        issue(1, 1'b0, F3_W, 'h008, 32'd0, 1'b1);
        issue(1, 1'b1, F3_W, 'h021, 32'hA1B2C3D4, 1'b1);
        issue(1, 1'b0, F3_W, 'h021, 32'd0, 1'b1);
        wait_idle();

        // Abort a store while dut1 sits in WAIT; it must never reach memory.
        issue(1, 1'b1, F3_W, 'h010, 32'h11223344, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset(1);
        check_reset(0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(1, 1'b0, F3_W, 'h010, 32'd0, 1'b1);
        wait_idle();

        for (int n = 0; n < 300; n++) begin
            int          d, a;
            bit          we;
            logic [2:0]  f3;
            d  = int'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = int'($urandom_range(0, 530));
            if ($urandom_range(0, 1) == 0) a = a & ~3;
            issue(d, we, f3, a, $urandom, 1'b1);
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
